// File: rtl/mips_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_check_pkg
//  Purpose  : Shared types and default constants for the store checker.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_check_pkg;

    // Width of the encoded checker state
    localparam int c_state_w = 2;

    // Default pass/skip addresses, pass data and timeout
    localparam logic [31:0] c_def_pass_addr      = 32'd84;
    localparam logic [31:0] c_def_pass_data      = 32'd7;
    localparam logic [31:0] c_def_skip_addr      = 32'd80;
    localparam logic [15:0] c_def_timeout_cycles = 16'd1000;

    // Checker FSM states; everything except ST_RUN is terminal
    typedef enum logic [c_state_w-1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/store_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_checker_if
//  Purpose  : CPU store bus plus verdict outputs of the store checker.
//  Revision : 1.0 - initial release
// ============================================================================
interface store_checker_if;

    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [7:0]  store_count;
    logic [31:0] last_addr;
    logic [31:0] last_data;

    // CPU / environment side: drives stores, observes the verdict
    modport master (
        output memwrite, dataadr, writedata,
        input  done, pass, fail, timeout, store_count, last_addr, last_data
    );

    // Checker side
    modport slave (
        input  memwrite, dataadr, writedata,
        output done, pass, fail, timeout, store_count, last_addr, last_data
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up counter that sticks at its all-ones value.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_count
);

    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Count up on request, holding once the maximum is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/store_checker.sv
`default_nettype none
// ============================================================================
//  Module   : store_checker
//  Purpose  : Watches CPU stores and declares pass, fail or timeout.
//             A rising memwrite is one store event; a magic store ends the
//             run as passed, skip stores are tolerated, anything else fails.
//  Revision : 1.0 - initial release
// ============================================================================
module store_checker
    import mips_check_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = c_def_pass_addr,
    parameter logic [31:0] PASS_DATA      = c_def_pass_data,
    parameter logic [31:0] SKIP_ADDR      = c_def_skip_addr,
    parameter logic [15:0] TIMEOUT_CYCLES = c_def_timeout_cycles
) (
    input  wire logic         clk,
    input  wire logic         reset,
    store_checker_if.slave    bus
);

    localparam logic [15:0] c_expire_cnt = TIMEOUT_CYCLES - 16'd1;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_prev_memwrite;
    logic        r_rst_d;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [31:0] r_last_addr;
    logic [31:0] r_last_data;
    logic [7:0]  w_store_count;
    logic [15:0] w_cycle_count;
    logic        w_store_evt;
    logic        w_in_run;
    logic        w_is_pass;
    logic        w_is_accept;
    logic        w_expire;
    logic        w_capture;

    // The edge right after reset release is masked so a memwrite that was
    // already high while in reset is not mistaken for a new store.
    assign w_store_evt = bus.memwrite & ~r_prev_memwrite & ~r_rst_d;
    assign w_in_run    = (r_state == ST_RUN);
    assign w_is_pass   = (bus.dataadr == PASS_ADDR) && (bus.writedata == PASS_DATA);
    assign w_is_accept = (bus.dataadr == SKIP_ADDR) || (bus.writedata == PASS_DATA);
    assign w_expire    = (w_cycle_count == c_expire_cnt);

    // Previous memwrite and delayed reset for store edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_memwrite <= 1'b0;
            r_rst_d         <= 1'b1;
        end else begin
            r_prev_memwrite <= bus.memwrite;
            r_rst_d         <= 1'b0;
        end
    end

    // Accepted stores seen while running
    sat_counter #(
        .WIDTH (8)
    ) u_store_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_in_run & w_store_evt),
        .o_count (w_store_count)
    );

    // Cycles spent running, for the timeout
    sat_counter #(
        .WIDTH (16)
    ) u_cycle_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_in_run),
        .o_count (w_cycle_count)
    );

    // Next-state decode; a store verdict outranks a simultaneous expiry
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_store_evt) begin
                    if (w_is_pass) begin
                        w_state_next = ST_PASS;
                        w_capture    = 1'b1;
                    end else if (w_is_accept) begin
                        if (w_expire) begin
                            w_state_next = ST_TIMEOUT;
                        end
                    end else begin
                        w_state_next = ST_FAIL;
                        w_capture    = 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_next = ST_TIMEOUT;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    // State register; terminal states hold until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Verdict flags registered from the next state so they rise on the
    // transition edge itself
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= (w_state_next != ST_RUN);
            r_pass    <= (w_state_next == ST_PASS);
            r_fail    <= (w_state_next == ST_FAIL);
            r_timeout <= (w_state_next == ST_TIMEOUT);
        end
    end

    // Capture the store that decided the run
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_addr <= 32'd0;
            r_last_data <= 32'd0;
        end else if (w_capture) begin
            r_last_addr <= bus.dataadr;
            r_last_data <= bus.writedata;
        end
    end

    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.fail        = r_fail;
    assign bus.timeout     = r_timeout;
    assign bus.store_count = w_store_count;
    assign bus.last_addr   = r_last_addr;
    assign bus.last_data   = r_last_data;

endmodule
`default_nettype wire

// File: tb/tb_store_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_checker
//  Purpose  : Directed scoreboard bench for store_checker (three instances:
//             default timeout, timeout 20, timeout 10).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_checker;

    localparam int F_DONE = 0, F_PASS = 1, F_FAIL = 2, F_TMO = 3,
                   F_CNT = 4, F_ADDR = 5, F_DATA = 6;

    typedef struct {
        int          dut;
        int          fld;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    store_checker_if bus_a ();
    store_checker_if bus_b ();
    store_checker_if bus_c ();

    store_checker dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    store_checker #(.TIMEOUT_CYCLES(16'd20)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));
    store_checker #(.TIMEOUT_CYCLES(16'd10)) dut_c (.clk(clk), .reset(rst_c), .bus(bus_c));

    always #5 clk = ~clk;

    function automatic string fname(int f);
        case (f)
            F_DONE:  return "done";
            F_PASS:  return "pass";
            F_FAIL:  return "fail";
            F_TMO:   return "timeout";
            F_CNT:   return "store_count";
            F_ADDR:  return "last_addr";
            default: return "last_data";
        endcase
    endfunction

    function automatic logic [31:0] observe(int d, int f);
        logic [31:0] v;
        v = 32'hx;
        if (d == 0) begin
            case (f)
                F_DONE:  v = {31'd0, bus_a.done};
                F_PASS:  v = {31'd0, bus_a.pass};
                F_FAIL:  v = {31'd0, bus_a.fail};
                F_TMO:   v = {31'd0, bus_a.timeout};
                F_CNT:   v = {24'd0, bus_a.store_count};
                F_ADDR:  v = bus_a.last_addr;
                default: v = bus_a.last_data;
            endcase
        end else if (d == 1) begin
            case (f)
                F_DONE:  v = {31'd0, bus_b.done};
                F_PASS:  v = {31'd0, bus_b.pass};
                F_FAIL:  v = {31'd0, bus_b.fail};
                F_TMO:   v = {31'd0, bus_b.timeout};
                F_CNT:   v = {24'd0, bus_b.store_count};
                F_ADDR:  v = bus_b.last_addr;
                default: v = bus_b.last_data;
            endcase
        end else begin
            case (f)
                F_DONE:  v = {31'd0, bus_c.done};
                F_PASS:  v = {31'd0, bus_c.pass};
                F_FAIL:  v = {31'd0, bus_c.fail};
                F_TMO:   v = {31'd0, bus_c.timeout};
                F_CNT:   v = {24'd0, bus_c.store_count};
                F_ADDR:  v = bus_c.last_addr;
                default: v = bus_c.last_data;
            endcase
        end
        return v;
    endfunction

    // Push one expected value
    task automatic push(input int d, input int f, input logic [31:0] v);
        exp_t e;
        e.dut = d;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    // Push the four verdict flags (done is derived as their OR)
    task automatic push_flags(input int d, input logic p, input logic f, input logic t);
        push(d, F_PASS, {31'd0, p});
        push(d, F_FAIL, {31'd0, f});
        push(d, F_TMO,  {31'd0, t});
        push(d, F_DONE, {31'd0, p | f | t});
    endtask

    // Pop every pending expectation and compare against the DUT
    task automatic check_now(input string step);
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.dut, e.fld);
            n_total++;
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s dut%0d.%s observed=0x%0h expected=0x%0h",
                        step, e.dut, fname(e.fld), obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic mw, input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            bus_a.memwrite = mw; bus_a.dataadr = a; bus_a.writedata = w;
        end else if (d == 1) begin
            bus_b.memwrite = mw; bus_b.dataadr = a; bus_b.writedata = w;
        end else begin
            bus_c.memwrite = mw; bus_c.dataadr = a; bus_c.writedata = w;
        end
    endtask

    // One single-cycle store on dut_a followed by an idle cycle
    task automatic store_a(input logic [31:0] a, input logic [31:0] w);
        drive(0, 1'b1, a, w);
        tick();
        drive(0, 1'b0, a, w);
        tick();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 32'd0, 32'd0);
        drive(2, 1'b0, 32'd0, 32'd0);
        tick();
        tick();

        // Reset state on all instances
        for (int d = 0; d < 3; d++) begin
            push_flags(d, 1'b0, 1'b0, 1'b0);
            push(d, F_CNT, 32'd0);
            push(d, F_ADDR, 32'd0);
            push(d, F_DATA, 32'd0);
        end
        check_now("reset");

        // Timeout instances: idle from reset release
        rst_b = 1'b0;
        rst_c = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        drive(2, 1'b1, 32'd84, 32'd7);        // pass store on dut_c expiry edge
        tick();
        push_flags(2, 1'b1, 1'b0, 1'b0);
        push(2, F_CNT, 32'd1);
        push(2, F_ADDR, 32'd84);
        push(2, F_DATA, 32'd7);
        check_now("store_on_expiry");
        drive(2, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) tick();   // 19 cycles in run on dut_b
        push_flags(1, 1'b0, 1'b0, 1'b0);
        check_now("before_timeout");
        tick();                               // 20th cycle
        push_flags(1, 1'b0, 1'b0, 1'b1);
        push(1, F_CNT, 32'd0);
        check_now("timeout20");

        // Pass sequence
        rst_a = 1'b0;
        tick();
        store_a(32'd80, 32'h12);
        push_flags(0, 1'b0, 1'b0, 1'b0);
        push(0, F_CNT, 32'd1);
        check_now("skip_store");
        drive(0, 1'b1, 32'd84, 32'd7);
        tick();
        push_flags(0, 1'b1, 1'b0, 1'b0);
        push(0, F_CNT, 32'd2);
        push(0, F_ADDR, 32'd84);
        push(0, F_DATA, 32'd7);
        check_now("pass_store");
        drive(0, 1'b0, 32'd0, 32'd0);
        tick();

        // Fail sequence, later pass store ignored
        rst_a = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        tick();
        drive(0, 1'b1, 32'h44, 32'd3);
        tick();
        push_flags(0, 1'b0, 1'b1, 1'b0);
        push(0, F_CNT, 32'd1);
        push(0, F_ADDR, 32'h44);
        push(0, F_DATA, 32'd3);
        check_now("fail_store");
        drive(0, 1'b0, 32'd0, 32'd0);
        tick();
        store_a(32'd84, 32'd7);
        push_flags(0, 1'b0, 1'b1, 1'b0);
        push(0, F_CNT, 32'd1);
        push(0, F_ADDR, 32'h44);
        push(0, F_DATA, 32'd3);
        check_now("terminal_ignores");

        // One-cycle reset out of FAIL, then pass
        rst_a = 1'b1;
        tick();
        push_flags(0, 1'b0, 1'b0, 1'b0);
        push(0, F_CNT, 32'd0);
        push(0, F_ADDR, 32'd0);
        push(0, F_DATA, 32'd0);
        check_now("reset_from_fail");
        rst_a = 1'b0;
        tick();
        store_a(32'd84, 32'd7);
        push_flags(0, 1'b1, 1'b0, 1'b0);
        push(0, F_CNT, 32'd1);
        check_now("pass_after_reset");

        // memwrite high across reset release is not a store
        drive(0, 1'b1, 32'd84, 32'd7);
        rst_a = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        tick();
        tick();
        push_flags(0, 1'b0, 1'b0, 1'b0);
        push(0, F_CNT, 32'd0);
        check_now("held_through_reset");
        drive(0, 1'b0, 32'd0, 32'd0);
        tick();

        // Held memwrite counts once
        drive(0, 1'b1, 32'd80, 32'd5);
        tick();
        tick();
        tick();
        drive(0, 1'b0, 32'd80, 32'd5);
        tick();
        push_flags(0, 1'b0, 1'b0, 1'b0);
        push(0, F_CNT, 32'd1);
        check_now("held_counts_once");

        // Saturation of store_count
        for (int i = 0; i < 300; i++) store_a(32'd80, 32'(i + 100));
        push_flags(0, 1'b0, 1'b0, 1'b0);
        push(0, F_CNT, 32'd255);
        check_now("saturate");
        store_a(32'd84, 32'd7);
        push_flags(0, 1'b1, 1'b0, 1'b0);
        push(0, F_CNT, 32'd255);
        push(0, F_ADDR, 32'd84);
        push(0, F_DATA, 32'd7);
        check_now("pass_when_saturated");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_checker.md
STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameter PASS_ADDR, default 32'd84: store address that, together with PASS_DATA, ends the run as passed.
REQ-002 Parameter PASS_DATA, default 32'd7: store data value that, together with PASS_ADDR, ends the run as passed.
REQ-003 Parameter SKIP_ADDR, default 32'd80: store address always accepted without a verdict.
REQ-004 Parameter TIMEOUT_CYCLES, default 16'd1000: cycles after reset release with no verdict before a timeout is declared.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port memwrite, input, 1: CPU store strobe, sampled on the rising edge of clk.
REQ-008 Port dataadr, input, 32: CPU store byte address.
REQ-009 Port writedata, input, 32: CPU store data.
REQ-010 Port done, output, 1: a verdict (pass, fail or timeout) has been reached.
REQ-011 Port pass, output, 1: the run ended with a store of PASS_DATA to PASS_ADDR.
REQ-012 Port fail, output, 1: the run ended with an illegal store.
REQ-013 Port timeout, output, 1: TIMEOUT_CYCLES elapsed with no verdict.
REQ-014 Port store_count, output, 8: number of accepted stores, saturating.
REQ-015 Port last_addr, output, 32: address of the store that produced the verdict.
REQ-016 Port last_data, output, 32: data of the store that produced the verdict.

Function
REQ-017 The FSM states shall be RUN, PASS, FAIL and TIMEOUT; PASS, FAIL and TIMEOUT are terminal and sticky until reset.
REQ-018 A store event shall occur on a clock edge where memwrite=1 and the registered previous memwrite=0; a held-high memwrite counts once.
REQ-019 In RUN, a store event with dataadr==PASS_ADDR and writedata==PASS_DATA shall move the FSM to PASS on that edge.
REQ-020 In RUN, any other store event with dataadr==SKIP_ADDR or writedata==PASS_DATA shall be accepted and the FSM shall stay in RUN.
REQ-021 In RUN, any remaining store event shall move the FSM to FAIL.
REQ-022 Each store event in RUN, including the one that produces a verdict, shall increment store_count, which saturates at 255.
REQ-023 On the edge that produces a PASS or FAIL verdict, last_addr and last_data shall capture dataadr and writedata; they shall hold thereafter.
REQ-024 The cycle counter shall increment every cycle in RUN; when it reaches TIMEOUT_CYCLES-1 with no store event on that edge, the FSM shall move to TIMEOUT.
REQ-025 If a store event and timeout expiry coincide, the store verdict shall have priority; an accepted store on that edge shall still cause TIMEOUT.
REQ-026 done, pass, fail and timeout shall be registered outputs asserted in the first cycle after the transition.
REQ-027 pass, fail and timeout shall be mutually exclusive, and done shall equal their OR.
REQ-028 In a terminal state, store events shall be ignored: no count, no capture, no state change.
REQ-029 Latency from the verdict edge to the visible output shall be 0 cycles, i.e. the outputs update on the same edge.
REQ-030 The block shall be synthesizable, with no $display or $stop.

Reset
REQ-031 While reset=1 on a rising edge, the FSM shall go to RUN; done, pass, fail and timeout shall be 0; store_count, the cycle counter, last_addr, last_data and the previous-memwrite register shall be 0.
REQ-032 Reset asserted in any state, including mid-run or terminal, shall take effect on the next edge.
REQ-033 A memwrite already high when reset deasserts shall not count as a store event.

Structure
REQ-034 The state enum typedef and the default PASS/SKIP/TIMEOUT constants shall live in the shared package mips_check_pkg.
REQ-035 The saturating counter shall be the sub-module sat_counter (parameter WIDTH), used for both store_count and the cycle counter.

Verification
REQ-036 Reset for 2 cycles, then stores (80,0x12), (84,7) -> pass=1, done=1, store_count=2, last_addr=84, last_data=7.
REQ-037 A store of (0x44,3) -> fail=1 on that edge, last_addr=0x44, last_data=3; a later store of (84,7) leaves fail=1 and pass=0.
REQ-038 No stores with TIMEOUT_CYCLES=20 -> timeout=1 after exactly 20 cycles in RUN; pass=0 and fail=0.
REQ-039 memwrite held high for 3 cycles with (80,5) -> store_count=1; then 300 single-cycle (80,x) stores -> store_count=255.
REQ-040 Reach fail=1, assert reset for 1 cycle -> all outputs are 0 and the FSM is in RUN; a following store of (84,7) -> pass=1.
REQ-041 A store of (84,7) on the expiry edge with TIMEOUT_CYCLES=10 -> pass=1 and timeout=0.
